sr_flag_arbiter: RTL and testbench

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

---
 rtl/sr_arb_pkg.sv | 22 ++
 rtl/sr_rr_pick.sv | 35 +++
 rtl/sr_flag_arbiter.sv | 110 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_arb_pkg.sv
// Shared constants and helpers for the SR flag arbiter.
// Holds the default bank geometry, the pointer width, and the index-to-one-hot
// conversion used to build the grant vector.
package sr_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int NFLAG_DEF = 8;
    localparam int PTR_W_DEF = $clog2(NREQ_DEF);

    // Widest requester count the conversion helper covers.
    localparam int MAX_NREQ  = 32;
    localparam int MAX_PTR_W = $clog2(MAX_NREQ);

    // Index to one-hot; callers cast the result down to their own NREQ width.
    function automatic logic [MAX_NREQ-1:0] idx_to_onehot(input logic [MAX_PTR_W-1:0] idx);
        logic [MAX_NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sr_rr_pick.sv
// Combinational round-robin picker: returns the first eligible index at or
// after ptr, wrapping from NREQ-1 back to 0, plus a valid flag.
module sr_rr_pick
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = PTR_W_DEF
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_vld
);

    int cand;

    // Scan NREQ positions starting at ptr and keep the first eligible one.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        win_idx = '0;
        win_vld = 1'b0;
        cand    = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_vld && elig[PTR_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a shared bank of
// NFLAG set/reset flags. One command is applied per clock; a requester is
// excluded in its own grant cycle. Bits both set and cleared by the same
// command hold their value and raise a one-cycle err pulse.
// Optional feature: define SR_ARB_LOCK_EN to add the lock input, which lets a
// locked winner keep the round-robin pointer on itself.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int NFLAG = NFLAG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
`ifdef SR_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    input  logic [NREQ*NFLAG-1:0] set_mask,
    input  logic [NREQ*NFLAG-1:0] clr_mask,
    output logic [NREQ-1:0]       gnt,
    output logic [NFLAG-1:0]      q,
    output logic [NFLAG-1:0]      qb,
    output logic                  err,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NFLAG-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0]  elig;
    logic [PTR_W-1:0] win_idx;
    logic             win_vld;
    logic [PTR_W-1:0] ptr_inc;
    logic [NFLAG-1:0] set_w, clr_w, ovl;

    // A requester holding gnt this cycle has just been served and sits out.
    assign elig = req & ~gnt_q;

    sr_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Select the winner's set/clear slices from the packed mask buses.
    always_comb begin
        set_w = '0;
        clr_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                set_w = set_mask[i*NFLAG +: NFLAG];
                clr_w = clr_mask[i*NFLAG +: NFLAG];
            end
        end
    end

    assign ovl     = set_w & clr_w;
    assign ptr_inc = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

    // Next state: apply the winning command, or idle with q and ptr held.
    always_comb begin
        q_d   = q_q;
        ptr_d = ptr_q;
        gnt_d = '0;
        err_d = 1'b0;
        if (win_vld) begin
            q_d   = (q_q & ~clr_w & ~ovl) | (set_w & ~ovl);
            gnt_d = NREQ'(idx_to_onehot(MAX_PTR_W'(win_idx)));
            err_d = |ovl;
            ptr_d = ptr_inc;
`ifdef SR_ARB_LOCK_EN
            if (lock[win_idx]) begin
                ptr_d = win_idx;
            end
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rst) begin
            q_q   <= '0;
            gnt_q <= '0;
            err_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            q_q   <= q_d;
            gnt_q <= gnt_d;
            err_q <= err_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign qb   = ~q_q;
    assign err  = err_q;
    assign busy = |elig;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed testbench for sr_flag_arbiter (NREQ=4, NFLAG=8).
// Build with SR_ARB_LOCK_EN defined to also exercise the lock input.
module tb_sr_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
`ifdef SR_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  qb;
    logic        err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(
        .NREQ  (4),
        .NFLAG (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
`ifdef SR_ARB_LOCK_EN
        .lock     (lock),
`endif
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .gnt      (gnt),
        .q        (q),
        .qb       (qb),
        .err      (err),
        .busy     (busy)
    );

    // Advance one rising edge, then settle away from it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req      = '0;
        set_mask = '0;
        clr_mask = '0;
`ifdef SR_ARB_LOCK_EN
        lock     = '0;
`endif
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        req      = 4'hF;
        set_mask = '1;
        clr_mask = '0;
        tick();
        tick();
        checks++;
        if (q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
        checks++;
        if (qb !== 8'hFF) begin failures++; $display("FAIL reset_qb: got %h expected %h", qb, 8'hFF); end
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
        rst = 1'b1;
        idle();
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL post_reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_set_clear();
        req           = 4'b0001;
        set_mask[7:0] = 8'h0F;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL sc_busy_pending: got %b expected %b", busy, 1'b1); end
        tick();
        checks++;
        if (q !== 8'h0F) begin failures++; $display("FAIL sc_set_q: got %h expected %h", q, 8'h0F); end
        checks++;
        if (qb !== 8'hF0) begin failures++; $display("FAIL sc_set_qb: got %h expected %h", qb, 8'hF0); end
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL sc_set_gnt: got %b expected %b", gnt, 4'b0001); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL sc_set_err: got %b expected %b", err, 1'b0); end
        // req0 still high but masked by its own gnt.
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL sc_busy_masked: got %b expected %b", busy, 1'b0); end
        idle();
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL sc_idle_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++;
        if (q !== 8'h0F) begin failures++; $display("FAIL sc_idle_q: got %h expected %h", q, 8'h0F); end
        req           = 4'b0001;
        clr_mask[7:0] = 8'h03;
        tick();
        checks++;
        if (q !== 8'h0C) begin failures++; $display("FAIL sc_clr_q: got %h expected %h", q, 8'h0C); end
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL sc_clr_gnt: got %b expected %b", gnt, 4'b0001); end
        idle();
        tick();
    endtask

    task automatic test_zero_masks();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL zero_gnt: got %b expected %b", gnt, 4'b0010); end
        checks++;
        if (q !== 8'h0C) begin failures++; $display("FAIL zero_q: got %h expected %h", q, 8'h0C); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL zero_err: got %b expected %b", err, 1'b0); end
        idle();
        tick();
    endtask

    task automatic test_overlap();
        // q=0C, set=81, clr=85: bits 7 and 0 overlap and hold at 0, bit 2 is
        // cleared, bit 3 untouched -> 08.
        req             = 4'b0100;
        set_mask[23:16] = 8'h81;
        clr_mask[23:16] = 8'h85;
        tick();
        checks++;
        if (q !== 8'h08) begin failures++; $display("FAIL ovl_q: got %h expected %h", q, 8'h08); end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL ovl_err_pulse: got %b expected %b", err, 1'b1); end
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL ovl_gnt: got %b expected %b", gnt, 4'b0100); end
        idle();
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL ovl_err_drop: got %b expected %b", err, 1'b0); end
        checks++;
        if (q !== 8'h08) begin failures++; $display("FAIL ovl_q_hold: got %h expected %h", q, 8'h08); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        rst = 1'b0;
        idle();
        tick();
        rst      = 1'b1;
        req      = 4'b1111;
        set_mask = 32'h0804_0201;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_gnt = 4'b0001 << (k % 4);
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
        end
        checks++;
        if (q !== 8'h0F) begin failures++; $display("FAIL rr_q: got %h expected %h", q, 8'h0F); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy: got %b expected %b", busy, 1'b1); end
        // Pointer is back at 0; sparse requests must skip idle indices and wrap.
        req = 4'b0000;
        tick();
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_gnt = (k == 1) ? 4'b1000 : 4'b0010;
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_skip_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        req             = 4'b0100;
        set_mask[23:16] = 8'hF0;
        rst             = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_rst_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++;
        if (q !== 8'h00) begin failures++; $display("FAIL mid_rst_q: got %h expected %h", q, 8'h00); end
        rst = 1'b1;
        idle();
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_rst_after_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++;
        if (q !== 8'h00) begin failures++; $display("FAIL mid_rst_after_q: got %h expected %h", q, 8'h00); end
    endtask

`ifdef SR_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] exp_gnt;
        rst = 1'b0;
        idle();
        tick();
        rst  = 1'b1;
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL lock_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
        end
        idle();
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_set_clear();
        test_zero_masks();
        test_overlap();
        test_round_robin();
        test_reset_mid();
`ifdef SR_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
